// File: rtl/mat_pkg.sv
// Shared matrix-IP types: geometry, word/row types and a small index-width helper.
package mat_pkg;
    localparam int N      = 16;
    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] word_t;
    typedef word_t [N-1:0]             row_t;

    // Counter width able to hold 0..n-1, never zero bits wide.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/row_buf2.sv
// Two-entry ping-pong row FIFO. The caller must not push when full or pop when empty.
module row_buf2 #(
    parameter int N      = mat_pkg::N,
    parameter int DATA_W = mat_pkg::DATA_W
) (
    input  logic                   Clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [N-1:0][DATA_W-1:0] wr_row,
    output logic [N-1:0][DATA_W-1:0] rd_row,
    output logic [1:0]             cnt,
    output logic                   not_full
);
    logic [N-1:0][DATA_W-1:0] mem [2];
    logic                     head;
    logic                     tail;
    logic [1:0]               cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + 2'd1;
            2'b01:   cnt_nxt = cnt - 2'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    // not_full is registered from the next occupancy, so it stays low through reset.
    always_ff @(posedge Clk or negedge rstn) begin
        if (!rstn) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            cnt      <= 2'd0;
            not_full <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= wr_row;
                tail      <= ~tail;
            end
            if (pop) head <= ~head;
            cnt      <= cnt_nxt;
            not_full <= (cnt_nxt != 2'd2);
        end
    end

    assign rd_row = mem[head];
endmodule

// File: rtl/mat_result_streamer.sv
// Serialises buffered result rows onto the 32-bit output stream, row-major,
// flagging the last word of each N x N matrix and pulsing done after it leaves.
module mat_result_streamer #(
    parameter int N      = 16,
    parameter int DATA_W = 32
) (
    input  logic                Clk,
    input  logic                rstn,
    input  logic [N*DATA_W-1:0] row_data,
    input  logic                row_valid,
    output logic                row_ready,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_valid,
    input  logic                o_ready,
    output logic                o_last,
    output logic                busy,
    output logic                done
);
    import mat_pkg::*;

    localparam int IW = idx_w(N);

    logic [IW-1:0]            col;
    logic [IW-1:0]            row;
    logic [1:0]               cnt;
    logic [N-1:0][DATA_W-1:0] head_row;
    logic                     push;
    logic                     pop;
    logic                     beat;
    logic                     col_end;
    logic                     row_end;

    assign push    = row_valid && row_ready;
    assign beat    = o_valid && o_ready;
    assign col_end = (col == IW'(N - 1));
    assign row_end = (row == IW'(N - 1));
    assign pop     = beat && col_end;

    row_buf2 #(.N(N), .DATA_W(DATA_W)) u_buf (
        .Clk      (Clk),
        .rstn     (rstn),
        .push     (push),
        .pop      (pop),
        .wr_row   (row_data),
        .rd_row   (head_row),
        .cnt      (cnt),
        .not_full (row_ready)
    );

    always_ff @(posedge Clk or negedge rstn) begin
        if (!rstn) begin
            col  <= '0;
            row  <= '0;
            done <= 1'b0;
        end else begin
            done <= beat && o_last;
            if (beat) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + IW'(1);
                end else begin
                    col <= col + IW'(1);
                end
            end
        end
    end

    // Pushes only touch the tail entry, so the head word is stable while stalled.
    assign o_valid = (cnt != 2'd0);
    assign o_data  = o_valid ? head_row[col] : '0;
    assign o_last  = o_valid && col_end && row_end;
    assign busy    = o_valid || (row != '0) || (col != '0);
endmodule

// File: tb/tb_mat_result_streamer.sv
module tb_mat_result_streamer;
    localparam int N  = 16;
    localparam int DW = 32;

    logic            Clk;
    logic            rstn;
    logic [N*DW-1:0] row_data;
    logic            row_valid;
    logic            row_ready;
    logic [DW-1:0]   o_data;
    logic            o_valid;
    logic            o_ready;
    logic            o_last;
    logic            busy;
    logic            done;

    mat_result_streamer #(.N(N), .DATA_W(DW)) dut (
        .Clk(Clk), .rstn(rstn), .row_data(row_data), .row_valid(row_valid),
        .row_ready(row_ready), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
        .o_last(o_last), .busy(busy), .done(done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // 0: o_ready=0, 1: o_ready=1, 2: 1,0,0,1 pattern, 3: driven by the test itself
    int mode = 3;
    int ocyc = 0;
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            ocyc++;
            case (mode)
                0: o_ready = 1'b0;
                1: o_ready = 1'b1;
                2: o_ready = ((ocyc % 4) == 0) || ((ocyc % 4) == 3);
                default: ;
            endcase
        end
    end

    // Beat monitor: records transferred words and checks stall stability and done timing.
    int          got[$];
    int          beat_cyc[$];
    int          last_idx[$];
    int          n_done = 0;
    int          done_bad = 0;
    int          mcyc = 0;
    logic        p_stall = 1'b0;
    logic        p_lastbeat = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic        p_last = 1'b0;

    always @(negedge Clk) begin
        mcyc++;
        if (rstn) begin
            if (p_stall) begin
                checks++;
                if (!o_valid || o_data != p_data || o_last != p_last) begin
                    errors++;
                    $display("FAIL hold: o_valid=%0b o_data=%0d o_last=%0b, required 1/%0d/%0b",
                             o_valid, o_data, o_last, p_data, p_last);
                end
            end
            if (done != p_lastbeat) done_bad++;
            if (done) n_done++;
            if (o_valid && o_ready) begin
                got.push_back(int'(o_data));
                beat_cyc.push_back(mcyc);
                if (o_last) last_idx.push_back(got.size() - 1);
            end
            p_stall    = o_valid && !o_ready;
            p_data     = o_data;
            p_last     = o_last;
            p_lastbeat = o_valid && o_ready && o_last;
        end else begin
            p_stall    = 1'b0;
            p_lastbeat = 1'b0;
        end
    end

    function automatic logic [N*DW-1:0] make_row(input int base);
        logic [N*DW-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++) r[c*DW +: DW] = DW'(base + c);
        return r;
    endfunction

    task automatic clear_mon();
        got.delete();
        beat_cyc.delete();
        last_idx.delete();
        n_done   = 0;
        done_bad = 0;
    endtask

    task automatic do_reset();
        mode      = 3;
        o_ready   = 1'b0;
        row_valid = 1'b0;
        rstn      = 1'b0;
        repeat (2) @(posedge Clk);
        #1 rstn = 1'b1;
        clear_mon();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_row(input int base);
        logic acc;
        int   t;
        acc = 1'b0;
        t = 0;
        row_valid = 1'b1;
        row_data  = make_row(base);
        while (!acc && t < 5000) begin
            @(negedge Clk);
            acc = row_ready;
            @(posedge Clk);
            #1;
            t++;
        end
        row_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: row base %0d not accepted, required acceptance", base);
        end
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 20000) begin
            @(negedge Clk);
            t++;
        end
        if (got.size() < n) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: %0d words, required %0d", got.size(), n);
        end
    endtask

    task automatic check_run(input string nm, input int n, input bit no_gap);
        int bad;
        repeat (3) @(negedge Clk);
        checks++;
        if (got.size() != n) begin
            errors++;
            $display("FAIL %s_count: %0d words, required %0d", nm, got.size(), n);
        end
        bad = -1;
        for (int i = 0; i < got.size(); i++)
            if (bad < 0 && got[i] != (i % 256)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_data: word %0d = %0d, required %0d", nm, bad, got[bad], bad % 256);
        end
        bad = (last_idx.size() != n / 256) ? 0 : -1;
        for (int k = 0; k < last_idx.size(); k++)
            if (bad < 0 && last_idx[k] != (k + 1) * 256 - 1) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_last: %0d o_last beats (first at %0d), required %0d at multiples of 256 minus 1",
                     nm, last_idx.size(), (last_idx.size() > 0) ? last_idx[0] : -1, n / 256);
        end
        checks++;
        if (n_done != n / 256 || done_bad != 0) begin
            errors++;
            $display("FAIL %s_done: %0d pulses, %0d mistimed, required %0d pulses, 0 mistimed",
                     nm, n_done, done_bad, n / 256);
        end
        if (no_gap) begin
            bad = -1;
            for (int i = 0; i < beat_cyc.size(); i++)
                if (bad < 0 && beat_cyc[i] != beat_cyc[0] + i) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s_gap: idle cycle before word %0d, required none", nm, bad);
            end
        end
        checks++;
        if (o_valid || busy) begin
            errors++;
            $display("FAIL %s_idle: o_valid=%0b busy=%0b, required 0/0", nm, o_valid, busy);
        end
    endtask

    typedef struct {
        logic        rv;
        int          base;
        logic        ordy;
        logic        e_rr;
        logic        e_ov;
        logic [DW-1:0] e_od;
        logic        e_busy;
    } tv_t;

    tv_t tv [41];

    task automatic set_tv(input int i, input logic rv, input int base, input logic ordy,
                          input logic rr, input logic ov, input int od, input logic bz);
        tv[i].rv = rv;  tv[i].base = base; tv[i].ordy = ordy;
        tv[i].e_rr = rr; tv[i].e_ov = ov;  tv[i].e_od = DW'(od); tv[i].e_busy = bz;
    endtask

    initial begin
        // Push/pop on the same edge, then fill the buffer with o_ready low and drain it.
        set_tv(0, 1, 500, 1, 1, 0, 0, 0);
        for (int k = 1; k <= 15; k++) set_tv(k, 0, 0, 1, 1, 1, 500 + k - 1, 1);
        set_tv(16, 1, 600, 1, 1, 1, 515, 1);
        set_tv(17, 0, 0, 1, 1, 1, 600, 1);
        set_tv(18, 0, 0, 0, 1, 1, 601, 1);
        set_tv(19, 0, 0, 0, 1, 1, 601, 1);
        set_tv(20, 1, 700, 0, 1, 1, 601, 1);
        set_tv(21, 1, 800, 0, 0, 1, 601, 1);
        set_tv(22, 1, 800, 0, 0, 1, 601, 1);
        for (int k = 23; k <= 37; k++) set_tv(k, 1, 800, 1, 0, 1, 601 + k - 23, 1);
        set_tv(38, 1, 800, 1, 1, 1, 700, 1);
        set_tv(39, 0, 0, 1, 0, 1, 701, 1);
        set_tv(40, 0, 0, 0, 0, 1, 702, 1);

        rstn = 1'b1; row_valid = 1'b0; row_data = '0; o_ready = 1'b0;
        #2 rstn = 1'b0;
        @(negedge Clk);
        checks++;
        if (o_valid || row_ready || o_last || busy || done || o_data != '0) begin
            errors++;
            $display("FAIL reset: ov=%0b rr=%0b last=%0b busy=%0b done=%0b data=%0d, required all 0",
                     o_valid, row_ready, o_last, busy, done, o_data);
        end
        @(posedge Clk);
        #1 rstn = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (row_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: row_ready=%0b, required 1", row_ready);
        end

        do_reset();
        for (int i = 0; i < 41; i++) begin
            row_valid = tv[i].rv;
            row_data  = make_row(tv[i].base);
            o_ready   = tv[i].ordy;
            @(negedge Clk);
            checks++;
            if (row_ready != tv[i].e_rr || o_valid != tv[i].e_ov || o_data != tv[i].e_od ||
                busy != tv[i].e_busy || o_last || done) begin
                errors++;
                $display("FAIL vec%0d: rr=%0b ov=%0b data=%0d busy=%0b last=%0b done=%0b, required %0b %0b %0d %0b 0 0",
                         i, row_ready, o_valid, o_data, busy, o_last, done,
                         tv[i].e_rr, tv[i].e_ov, tv[i].e_od, tv[i].e_busy);
            end
            @(posedge Clk);
            #1;
        end

        do_reset();
        mode = 1;
        for (int r = 0; r < N; r++) push_row(r * 16);
        wait_beats(256);
        check_run("basic", 256, 1);

        do_reset();
        mode = 2;
        for (int r = 0; r < N; r++) push_row(r * 16);
        wait_beats(256);
        check_run("bp", 256, 0);

        do_reset();
        mode = 1;
        for (int r = 0; r < 2 * N; r++) push_row((r % N) * 16);
        wait_beats(512);
        check_run("b2b", 512, 1);

        do_reset();
        mode = 1;
        for (int r = 0; r < 4; r++) push_row(r * 16);
        wait_beats(41);
        @(posedge Clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (o_valid || busy || done || row_ready) begin
            errors++;
            $display("FAIL async_reset: ov=%0b busy=%0b done=%0b rr=%0b, required 0 0 0 0",
                     o_valid, busy, done, row_ready);
        end
        @(posedge Clk);
        @(posedge Clk);
        #1 rstn = 1'b1;
        clear_mon();
        @(posedge Clk);
        #1;
        for (int r = 0; r < N; r++) push_row(r * 16);
        wait_beats(256);
        check_run("rst_restart", 256, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
